// File: rtl/afe_seq_pkg.sv
// afe_seq_pkg: shared types for the Hall AFE spinning-current sequencer.
//   state_e   - sequencer FSM states
//   chan_e    - AFE channel select encoding (plate A, plate B, temperature)
//   phase_neg - sign of a spinning phase's contribution (odd phases subtract)
package afe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UPDATE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_WAIT    = 3'd4,
    ST_ACCUM   = 3'd5,
    ST_PUBLISH = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_T = 2'd2
  } chan_e;

  // Odd spinning phases see the Hall voltage reversed; subtracting them cancels
  // the plate offset while doubling the signal.
  function automatic logic phase_neg(input logic [1:0] phase);
    return phase[0];
  endfunction

endpackage

// File: rtl/afe_seq_timer.sv
// afe_seq_timer: loadable down counter, shared by the settle wait and the ADC
// timeout (the two are never active at the same time).
//   clk, rst    - clock, synchronous active-high reset
//   load_i      - load load_val_i (wins over dec_i)
//   load_val_i  - value to load
//   dec_i       - decrement by one, holding at zero
//   cnt_o       - current count
//   zero_o      - count is zero
module afe_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/afe_spin_sequencer.sv
// afe_spin_sequencer: steps the Hall AFE through 4-phase spinning-current
// measurement of plates A then B, settles, handshakes the ADC and accumulates
// offset-cancelled per-plate results.
// Optional feature macro: AFE_SEQ_TEMP_EN - appends one temperature sample
// (channel 2, phase 0, no sign) per frame and adds output res_t.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       run enable; low aborts to IDLE on the next edge
//   continuous               restart a new frame after each publish
//   settle_cycles            wait between phase update and ADC start
//   afe_chan, afe_phase      AFE channel / spinning phase select
//   afe_phase_update         1-cycle strobe, chan/phase already hold new values
//   adc_start / adc_done     ADC handshake, adc_data valid with adc_done
//   res_a, res_b (res_t)     frame results, held until next publish
//   res_valid                1-cycle pulse with updated results
//   busy, err_timeout        not idle; sticky ADC timeout flag
module afe_spin_sequencer
  import afe_seq_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int ACC_W    = 14,
  parameter int SETTLE_W = 8,
  parameter int TMO_CYC  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    continuous,
  input  logic [SETTLE_W-1:0]     settle_cycles,
  output logic [1:0]              afe_chan,
  output logic [1:0]              afe_phase,
  output logic                    afe_phase_update,
  output logic                    adc_start,
  input  logic                    adc_done,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic signed [ACC_W-1:0] res_a,
  output logic signed [ACC_W-1:0] res_b,
`ifdef AFE_SEQ_TEMP_EN
  output logic signed [ACC_W-1:0] res_t,
`endif
  output logic                    res_valid,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int TMR_W = (SETTLE_W > TMO_W) ? SETTLE_W : TMO_W;

  state_e                  state_q, state_d;
  logic [1:0]              chan_q, chan_d, phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [ACC_W-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
`ifdef AFE_SEQ_TEMP_EN
  logic signed [ACC_W-1:0] acc_t_q, acc_t_d, res_t_q, res_t_d;
`endif
  logic signed [ADC_W-1:0] smp_q, smp_d;
  logic                    res_valid_q, res_valid_d, err_q, err_d, en_q;

  logic                    tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]        tmr_val, tmr_cnt;

  logic signed [ACC_W-1:0] smp_ext, smp_acc;
  logic                    last_smp;

  afe_seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  assign smp_ext = {{(ACC_W-ADC_W){smp_q[ADC_W-1]}}, smp_q};
  assign smp_acc = phase_neg(phase_q) ? -smp_ext : smp_ext;

`ifdef AFE_SEQ_TEMP_EN
  assign last_smp = (chan_q == CH_T);
`else
  assign last_smp = (chan_q == CH_B) && (phase_q == 2'd3);
`endif

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    phase_d     = phase_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
`ifdef AFE_SEQ_TEMP_EN
    acc_t_d     = acc_t_q;
    res_t_d     = res_t_q;
`endif
    smp_d       = smp_q;
    res_valid_d = 1'b0;
    err_d       = err_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = TMR_W'(settle_cycles) - TMR_W'(1);

    if (en && !en_q) err_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          chan_d  = CH_A;
          phase_d = 2'd0;
          acc_a_d = '0;
          acc_b_d = '0;
`ifdef AFE_SEQ_TEMP_EN
          acc_t_d = '0;
`endif
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          // load settle-1 so SETTLE lasts exactly settle_cycles cycles
          tmr_load = 1'b1;
          state_d  = (settle_cycles == '0) ? ST_CONVERT : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_zero) state_d = ST_CONVERT;
          else          tmr_dec = 1'b1;
        end
        ST_CONVERT: begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TMO_CYC);
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          // Flag goes up during the last WAIT cycle, exit happens after it;
          // a done arriving in that final cycle is too late and ignored.
          if (tmr_zero) begin
            state_d = ST_IDLE;
          end else if (adc_done) begin
            smp_d   = adc_data;
            state_d = ST_ACCUM;
          end else begin
            tmr_dec = 1'b1;
            if (tmr_cnt == TMR_W'(1)) err_d = 1'b1;
          end
        end
        ST_ACCUM: begin
          case (chan_q)
            CH_A:    acc_a_d = acc_a_q + smp_acc;
            CH_B:    acc_b_d = acc_b_q + smp_acc;
`ifdef AFE_SEQ_TEMP_EN
            CH_T:    acc_t_d = acc_t_q + smp_ext;
`endif
            default: ;
          endcase
          if (last_smp) begin
            chan_d  = CH_A;
            phase_d = 2'd0;
            state_d = ST_PUBLISH;
          end else if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            chan_d  = chan_q + 2'd1;
            state_d = ST_UPDATE;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = ST_UPDATE;
          end
        end
        ST_PUBLISH: begin
          res_a_d     = acc_a_q;
          res_b_d     = acc_b_q;
`ifdef AFE_SEQ_TEMP_EN
          res_t_d     = acc_t_q;
`endif
          res_valid_d = 1'b1;
          if (continuous) begin
            acc_a_d = '0;
            acc_b_d = '0;
`ifdef AFE_SEQ_TEMP_EN
            acc_t_d = '0;
`endif
            chan_d  = CH_A;
            phase_d = 2'd0;
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      phase_q     <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
`ifdef AFE_SEQ_TEMP_EN
      acc_t_q     <= '0;
      res_t_q     <= '0;
`endif
      smp_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      phase_q     <= phase_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
`ifdef AFE_SEQ_TEMP_EN
      acc_t_q     <= acc_t_d;
      res_t_q     <= res_t_d;
`endif
      smp_q       <= smp_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      en_q        <= en;
    end
  end

  assign afe_chan         = chan_q;
  assign afe_phase        = phase_q;
  assign afe_phase_update = (state_q == ST_UPDATE);
  assign adc_start        = (state_q == ST_CONVERT);
  assign busy             = (state_q != ST_IDLE);
  assign res_valid        = res_valid_q;
  assign err_timeout      = err_q;
  assign res_a            = res_a_q;
  assign res_b            = res_b_q;
`ifdef AFE_SEQ_TEMP_EN
  assign res_t            = res_t_q;
`endif

endmodule

// File: tb/tb_afe_spin_sequencer.sv
// Directed bench for afe_spin_sequencer: table of single-frame vectors, then
// hand sequences for ADC timeout, continuous mode and mid-frame abort.
// The ADC model answers adc_start after 'lat' cycles with the sample picked
// by the current chan/phase (temperature channel answers -5).
module tb_afe_spin_sequencer;

  logic               clk = 1'b0;
  logic               rst, en, continuous;
  logic [7:0]         settle_cycles;
  logic [1:0]         afe_chan, afe_phase;
  logic               afe_phase_update, adc_start, adc_done;
  logic signed [11:0] adc_data;
  logic signed [13:0] res_a, res_b;
`ifdef AFE_SEQ_TEMP_EN
  logic signed [13:0] res_t;
  localparam int PU_FRAME = 9;
`else
  localparam int PU_FRAME = 8;
`endif
  logic               res_valid, busy, err_timeout;

  afe_spin_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .continuous       (continuous),
    .settle_cycles    (settle_cycles),
    .afe_chan         (afe_chan),
    .afe_phase        (afe_phase),
    .afe_phase_update (afe_phase_update),
    .adc_start        (adc_start),
    .adc_done         (adc_done),
    .adc_data         (adc_data),
    .res_a            (res_a),
    .res_b            (res_b),
`ifdef AFE_SEQ_TEMP_EN
    .res_t            (res_t),
`endif
    .res_valid        (res_valid),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        settle;
    logic [7:0]        lat;
    logic [7:0][11:0]  s;      // A0..A3 in s[0..3], B0..B3 in s[4..7]
    logic [13:0]       ea;
    logic [13:0]       eb;
  } vec_t;

  localparam int NV = 5;
  vec_t tbl [NV];
  vec_t cur;
  int   nvec = 0, nerr = 0;
  int   pu_cnt = 0, rv_cnt = 0, pu_age = 0, adc_cd = 0;
  bit   adc_mute = 0, gap_chk = 0;

  function automatic vec_t mkv(input int st, input int lat,
                               input int a0, input int a1, input int a2, input int a3,
                               input int b0, input int b1, input int b2, input int b3,
                               input int ea, input int eb);
    vec_t v;
    v.settle = 8'(st);  v.lat  = 8'(lat);
    v.s[0] = 12'(a0);   v.s[1] = 12'(a1); v.s[2] = 12'(a2); v.s[3] = 12'(a3);
    v.s[4] = 12'(b0);   v.s[5] = 12'(b1); v.s[6] = 12'(b2); v.s[7] = 12'(b3);
    v.ea = 14'(ea);     v.eb = 14'(eb);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: observe at the falling edge, then drive the ADC model.
  task automatic tick();
    int idx;
    @(negedge clk);
    pu_age++;
    if (afe_phase_update) begin pu_cnt++; pu_age = 0; end
    if (res_valid) rv_cnt++;
    adc_done = 1'b0;
    if (adc_cd > 0) begin
      adc_cd--;
      if (adc_cd == 0) begin
        adc_done = 1'b1;
        idx = int'(afe_chan) * 4 + int'(afe_phase);
        if (afe_chan == 2'd2) adc_data = -12'sd5;
        else                  adc_data = $signed(cur.s[idx[2:0]]);
      end
    end
    if (adc_start) begin
      if (gap_chk) chk("start_gap", pu_age, int'(cur.settle) + 1);
      if (!adc_mute) adc_cd = int'(cur.lat);
    end
  endtask

  initial begin
    int pu0, rv0, nf;
    bit got;

    // settle, lat, A0..A3, B0..B3, expected A0-A1+A2-A3, B0-B1+B2-B3
    tbl[0] = mkv(4,   10,  100,  -90,  110,  -80,    10,   20,    30,   40,   380,   -20);
    tbl[1] = mkv(0,   1,   2047, -2048, 2047, -2048, -2048, 2047, -2048, 2047, 8190, -8190);
    tbl[2] = mkv(1,   3,   1,    1,    1,    1,      7,    -3,    0,    1,     0,     9);
    tbl[3] = mkv(2,   5,   -1,   -1,   -1,   -1,     -100, 100,   -100, 100,   0,    -400);
    tbl[4] = mkv(255, 2,   12,   3,    4,    5,      0,    0,     0,    0,     8,     0);

    rst = 1'b1; en = 1'b0; continuous = 1'b0; settle_cycles = 8'd0;
    adc_done = 1'b0; adc_data = '0;
    cur = tbl[0];
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy",      int'(busy),             0);
    chk("rst_res_valid", int'(res_valid),        0);
    chk("rst_err",       int'(err_timeout),      0);
    chk("rst_res_a",     int'(res_a),            0);
    chk("rst_res_b",     int'(res_b),            0);
    chk("rst_chan",      int'(afe_chan),         0);
    chk("rst_phase",     int'(afe_phase),        0);
    chk("rst_strobes",   int'({afe_phase_update, adc_start}), 0);

    // single frames from the table
    gap_chk = 1'b1;
    for (int i = 0; i < NV; i++) begin
      cur = tbl[i]; settle_cycles = cur.settle; adc_cd = 0; adc_mute = 1'b0;
      pu0 = pu_cnt; rv0 = rv_cnt; got = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 6000 && !got; c++) begin
        tick();
        if (res_valid) got = 1'b1;
      end
      en = 1'b0;
      chk("frame_done", int'(got), 1);
      chk("res_a", int'(res_a), int'($signed(cur.ea)));
      chk("res_b", int'(res_b), int'($signed(cur.eb)));
`ifdef AFE_SEQ_TEMP_EN
      chk("res_t", int'(res_t), -5);
`endif
      chk("pu_per_frame", pu_cnt - pu0, PU_FRAME);
      repeat (3) tick();
      chk("idle_after_frame", int'(busy), 0);
      chk("one_res_valid", rv_cnt - rv0, 1);
      chk("res_a_hold", int'(res_a), int'($signed(cur.ea)));
    end

    // ADC never answers: flag rises in the 256th WAIT cycle, idle after it
    cur = tbl[0]; settle_cycles = cur.settle; adc_cd = 0; adc_mute = 1'b1;
    got = 1'b0; en = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      if (adc_start) got = 1'b1;
    end
    chk("tmo_start_seen", int'(got), 1);
    repeat (255) tick();
    chk("tmo_err_w255",  int'(err_timeout), 0);
    chk("tmo_busy_w255", int'(busy),        1);
    tick();
    chk("tmo_err_w256",  int'(err_timeout), 1);
    chk("tmo_busy_w256", int'(busy),        1);
    tick();
    chk("tmo_idle",      int'(busy),        0);
    en = 1'b0;
    repeat (2) tick();
    chk("tmo_sticky",    int'(err_timeout), 1);
    en = 1'b1;
    tick();
    chk("tmo_clr_on_en", int'(err_timeout), 0);
    en = 1'b0; adc_mute = 1'b0;
    repeat (3) tick();

    // continuous: three frames, accumulators cleared in between
    cur = tbl[0]; settle_cycles = cur.settle; adc_cd = 0;
    continuous = 1'b1; rv0 = rv_cnt; nf = 0; en = 1'b1;
    for (int c = 0; c < 20000 && nf < 3; c++) begin
      tick();
      if (res_valid) begin
        nf++;
        chk("cont_res_a", int'(res_a), 380);
        chk("cont_res_b", int'(res_b), -20);
      end
    end
    en = 1'b0; continuous = 1'b0;
    chk("cont_frames", nf, 3);
    repeat (3) tick();
    chk("cont_rv_pulses", rv_cnt - rv0, 3);
    chk("cont_idle",      int'(busy),   0);

    // en dropped while waiting on sample B2: results keep the previous frame
    cur = tbl[2]; settle_cycles = cur.settle; adc_cd = 0; rv0 = rv_cnt;
    got = 1'b0; en = 1'b1;
    for (int c = 0; c < 3000 && !got; c++) begin
      tick();
      if (adc_start && afe_chan == 2'd1 && afe_phase == 2'd2) got = 1'b1;
    end
    chk("abort_b2_seen", int'(got), 1);
    en = 1'b0;
    tick();
    chk("abort_busy",  int'(busy),  0);
    chk("abort_res_a", int'(res_a), 380);
    chk("abort_res_b", int'(res_b), -20);
    repeat (15) tick();
    chk("abort_still_idle", int'(busy),   0);
    chk("abort_no_publish", rv_cnt - rv0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
